bus_arbiter: RTL and testbench

Shared-bus arbiter and address decoder sitting between the bus masters (Core and future DMA) and the memory-mapped devices on the board top level. It accepts one request at a time from up to Num_master masters, selects a winner round-robin, decodes the address to one of Num_device device ports and runs a single req/gnt transfer on that device. It then returns read data and a one-cycle grant to the winning master. Unmapped addresses and unresponsive devices terminate with an error response, so masters never hang.

---
 rtl/bus_pkg.sv | 45 ++++
 rtl/bus_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 25 ++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter / address decoder.
// Region tags map addr[31:28] onto device ports.
package bus_pkg;

    localparam int AddrWidth  = 32;
    localparam int DataWidth  = 32;
    localparam int Num_master = 2;
    localparam int Num_device = 14;
    localparam int Timeout    = 255;

    localparam int MstIdxW = (Num_master > 1) ? $clog2(Num_master) : 1;
    localparam int DevIdxW = $clog2(Num_device);

    // Device 0 is RAM at 0x3000_0000; tags 0x0 and 0xF stay unmapped.
    localparam logic [3:0] DEV_TAG [Num_device] = '{
        4'h3, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE
    };

    localparam logic [DataWidth-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    typedef struct packed {
        logic               hit;
        logic [DevIdxW-1:0] idx;
    } dec_t;

    function automatic dec_t dev_decode(input logic [AddrWidth-1:0] addr);
        dec_t r;
        r = '0;
        for (int i = 0; i < Num_device; i++) begin
            if (!r.hit && addr[31:28] == DEV_TAG[i]) begin
                r.hit = 1'b1;
                r.idx = DevIdxW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and device-side bus signals of the arbiter.
// slave = arbiter view, master = environment view.
interface bus_arbiter_if import bus_pkg::*; ();

    logic [Num_master-1:0]                master_req;
    logic [Num_master-1:0][AddrWidth-1:0] master_req_addr;
    logic [Num_master-1:0]                master_read_write;
    logic [Num_master-1:0][DataWidth-1:0] master_wdata;
    logic [Num_master-1:0][DataWidth-1:0] master_rdata;
    logic [Num_master-1:0]                master_gnt;

    logic [Num_device-1:0][AddrWidth-1:0] device_addr;
    logic [Num_device-1:0]                device_re;
    logic [Num_device-1:0]                device_we;
    logic [Num_device-1:0][DataWidth-1:0] device_wdata;
    logic [Num_device-1:0][DataWidth-1:0] device_rdata;
    logic [Num_device-1:0]                device_gnt;

    modport slave (
        input  master_req, master_req_addr, master_read_write,
        input  master_wdata, device_rdata, device_gnt,
        output master_rdata, master_gnt, device_addr,
        output device_re, device_we, device_wdata
    );

    modport master (
        output master_req, master_req_addr, master_read_write,
        output master_wdata, device_rdata, device_gnt,
        input  master_rdata, master_gnt, device_addr,
        input  device_re, device_we, device_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among requesting masters.
// Search starts one past the last winner.
module rr_arbiter import bus_pkg::*; (
    input  logic [Num_master-1:0] req,
    input  logic [MstIdxW-1:0]    last,
    output logic                  valid,
    output logic [MstIdxW-1:0]    idx
);

    // first requester after the last winner, wrapping around
    always_comb begin
        int c;
        c     = 0;
        valid = 1'b0;
        idx   = last;
        for (int i = 1; i <= Num_master; i++) begin
            c = (int'(last) + i) % Num_master;
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = MstIdxW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin master select, address decode,
// one req/gnt device transfer, registered grant/response.
module bus_arbiter import bus_pkg::*; (
    input  logic          clk_i,
    input  logic          rst_i,
    bus_arbiter_if.slave  bus,
    output logic          bus_err_o
);

    state_t               state_q, state_d;
    logic [MstIdxW-1:0]   win_q, win_d;
    logic [MstIdxW-1:0]   last_q, last_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DevIdxW-1:0]   sel_q, sel_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_d;

    logic [Num_master-1:0]                mgnt_d;
    logic [Num_master-1:0][DataWidth-1:0] mrdata_d;
    logic [Num_device-1:0]                dre_d;
    logic [Num_device-1:0]                dwe_d;
    logic [Num_device-1:0][AddrWidth-1:0] daddr_d;
    logic [Num_device-1:0][DataWidth-1:0] dwdata_d;

    logic               arb_valid;
    logic [MstIdxW-1:0] arb_idx;
    dec_t               dec;

    rr_arbiter u_rr (
        .req   (bus.master_req),
        .last  (last_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign dec = dev_decode(bus.master_req_addr[arb_idx]);

    // next state, latched request fields and next registered outputs
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        err_d    = bus_err_o;
        mgnt_d   = '0;
        mrdata_d = '0;
        dre_d    = '0;
        dwe_d    = '0;
        daddr_d  = '0;
        dwdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    addr_d  = bus.master_req_addr[arb_idx];
                    rw_d    = bus.master_read_write[arb_idx];
                    wdata_d = bus.master_wdata[arb_idx];
                    sel_d   = dec.idx;
                    cnt_d   = '0;
                    if (dec.hit) begin
                        state_d = XFER;
                    end else begin
                        state_d           = RESP;
                        mgnt_d[arb_idx]   = 1'b1;
                        mrdata_d[arb_idx] = ERR_DATA;
                        err_d             = 1'b1;
                    end
                end
            end
            XFER: begin
                if (bus.device_gnt[sel_q]) begin
                    state_d         = RESP;
                    mgnt_d[win_q]   = 1'b1;
                    mrdata_d[win_q] = rw_q ? '0 : bus.device_rdata[sel_q];
                end else if (cnt_q == 8'(Timeout - 1)) begin
                    state_d         = RESP;
                    mgnt_d[win_q]   = 1'b1;
                    mrdata_d[win_q] = ERR_DATA;
                    err_d           = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = win_q;
            end
            default: state_d = IDLE;
        endcase
        // device strobes follow the next state so they are registered
        if (state_d == XFER) begin
            dre_d[sel_d]    = ~rw_d;
            dwe_d[sel_d]    = rw_d;
            daddr_d[sel_d]  = addr_d;
            dwdata_d[sel_d] = wdata_d;
        end
    end

    // state, request latch and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            win_q            <= '0;
            last_q           <= MstIdxW'(Num_master - 1);
            addr_q           <= '0;
            rw_q             <= 1'b0;
            wdata_q          <= '0;
            sel_q            <= '0;
            cnt_q            <= '0;
            bus_err_o        <= 1'b0;
            bus.master_gnt   <= '0;
            bus.master_rdata <= '0;
            bus.device_re    <= '0;
            bus.device_we    <= '0;
            bus.device_addr  <= '0;
            bus.device_wdata <= '0;
        end else begin
            state_q          <= state_d;
            win_q            <= win_d;
            last_q           <= last_d;
            addr_q           <= addr_d;
            rw_q             <= rw_d;
            wdata_q          <= wdata_d;
            sel_q            <= sel_d;
            cnt_q            <= cnt_d;
            bus_err_o        <= err_d;
            bus.master_gnt   <= mgnt_d;
            bus.master_rdata <= mrdata_d;
            bus.device_re    <= dre_d;
            bus.device_we    <= dwe_d;
            bus.device_addr  <= daddr_d;
            bus.device_wdata <= dwdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter: table of transfers plus
// hand sequences for reset-in-transfer and contention.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    logic bus_err;

    always #5 clk = ~clk;

    bus_arbiter_if bif ();

    bus_arbiter dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bif),
        .bus_err_o (bus_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int strobe_cnt;
    int act_dev;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        rw0;
        logic        rw1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        int          wait_n;
        logic [31:0] drd;
        int          exp_win;
        logic [31:0] exp_rd;
        int          exp_dev;
        int          exp_strobes;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock; device model grants the strobed device after wait_n
    // strobe cycles (0 = never) and pokes a non-selected gnt meanwhile
    task automatic step_resp(input int wait_n, input logic [31:0] drd);
        @(posedge clk);
        #1;
        bif.device_gnt   = '0;
        bif.device_rdata = {Num_device{32'h5555_AAAA}};
        act_dev = -1;
        for (int d = 0; d < Num_device; d++)
            if (bif.device_re[d] | bif.device_we[d]) act_dev = d;
        if (act_dev >= 0) begin
            strobe_cnt++;
            if (wait_n > 0 && strobe_cnt == wait_n) begin
                bif.device_gnt[act_dev]   = 1'b1;
                bif.device_rdata[act_dev] = drd;
            end else begin
                bif.device_gnt[(act_dev + 1) % Num_device] = 1'b1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int          lat;
        bit          seen;
        int          first_dev;
        logic [31:0] first_addr;
        logic [31:0] first_wd;
        logic        first_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        logic        exp_rw;
        exp_addr = (v.exp_win == 0) ? v.addr0 : v.addr1;
        exp_wd   = (v.exp_win == 0) ? v.wd0 : v.wd1;
        exp_rw   = (v.exp_win == 0) ? v.rw0 : v.rw1;
        bif.master_req_addr[0]   = v.addr0;
        bif.master_req_addr[1]   = v.addr1;
        bif.master_read_write[0] = v.rw0;
        bif.master_read_write[1] = v.rw1;
        bif.master_wdata[0]      = v.wd0;
        bif.master_wdata[1]      = v.wd1;
        bif.master_req           = v.req;
        strobe_cnt = 0;
        first_dev  = -1;
        first_addr = '0;
        first_wd   = '0;
        first_we   = 1'b0;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 400) begin
            step_resp(v.wait_n, v.drd);
            lat++;
            if (first_dev < 0 && act_dev >= 0) begin
                first_dev  = act_dev;
                first_addr = bif.device_addr[act_dev];
                first_wd   = bif.device_wdata[act_dev];
                first_we   = bif.device_we[act_dev];
            end
            if (bif.master_gnt != '0) seen = 1;
        end
        chk($sformatf("v%0d_gnt_seen", k), 64'(seen), 64'd1);
        chk($sformatf("v%0d_latency", k), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_gnt_vec", k), 64'(bif.master_gnt),
            64'(1 << v.exp_win));
        chk($sformatf("v%0d_rdata", k), 64'(bif.master_rdata[v.exp_win]),
            64'(v.exp_rd));
        chk($sformatf("v%0d_other_rdata", k),
            64'(bif.master_rdata[1 - v.exp_win]), 64'd0);
        chk($sformatf("v%0d_strobes", k), 64'(strobe_cnt),
            64'(v.exp_strobes));
        chk($sformatf("v%0d_dev", k), 64'(first_dev), 64'(v.exp_dev));
        if (v.exp_dev >= 0) begin
            chk($sformatf("v%0d_dev_addr", k), 64'(first_addr),
                64'(exp_addr));
            chk($sformatf("v%0d_dev_dir", k), 64'(first_we), 64'(exp_rw));
            if (exp_rw)
                chk($sformatf("v%0d_dev_wdata", k), 64'(first_wd),
                    64'(exp_wd));
        end
        chk($sformatf("v%0d_err", k), 64'(bus_err), 64'(v.exp_err));
        bif.master_req = '0;
        step_resp(0, '0);
        chk($sformatf("v%0d_gnt_one_cycle", k), 64'(bif.master_gnt), 64'd0);
        chk($sformatf("v%0d_rdata_clear", k), 64'(bif.master_rdata), 64'd0);
    endtask

    initial begin
        int g;
        int cyc;
        logic [1:0] gacc;

        vt[0] = '{2'b01, 32'h3000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1, 32'h1234_5678, 0, 32'h1234_5678, 0, 1, 2, 1'b0};
        vt[1] = '{2'b01, 32'h3000_0004, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D,
                  32'h0, 3, 32'h9999_9999, 0, 32'h0, 0, 3, 4, 1'b0};
        vt[2] = '{2'b10, 32'h0, 32'h4000_0100, 1'b0, 1'b0, 32'h0, 32'h0,
                  2, 32'hA5A5_0001, 1, 32'hA5A5_0001, 3, 2, 3, 1'b0};
        vt[3] = '{2'b11, 32'hE000_0008, 32'h1000_0000, 1'b0, 1'b0, 32'h0,
                  32'h0, 1, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 13, 1, 2, 1'b0};
        vt[4] = '{2'b11, 32'hE000_0008, 32'h2000_0020, 1'b0, 1'b1, 32'h0,
                  32'h1111_2222, 2, 32'h3333_3333, 1, 32'h0, 2, 2, 3, 1'b0};
        vt[5] = '{2'b01, 32'hF000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1, 32'h4444_4444, 0, 32'hDEAD_BEEF, -1, 0, 1, 1'b1};
        vt[6] = '{2'b10, 32'h0, 32'h3000_0000, 1'b0, 1'b0, 32'h0, 32'h0,
                  1, 32'h0000_0042, 1, 32'h0000_0042, 0, 1, 2, 1'b1};
        vt[7] = '{2'b01, 32'h5000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  0, 32'h0, 0, 32'hDEAD_BEEF, 4, 255, 256, 1'b1};
        vt[8] = '{2'b10, 32'h0, 32'h3000_0040, 1'b0, 1'b0, 32'h0, 32'h0,
                  1, 32'h7777_0000, 1, 32'h7777_0000, 0, 1, 2, 1'b1};

        rst_i                 = 1'b1;
        bif.master_req        = '0;
        bif.master_req_addr   = '0;
        bif.master_read_write = '0;
        bif.master_wdata      = '0;
        bif.device_rdata      = '0;
        bif.device_gnt        = '0;
        strobe_cnt            = 0;
        act_dev               = -1;
        step_resp(0, '0);
        step_resp(0, '0);
        rst_i = 1'b0;

        chk("rst_master_gnt", 64'(bif.master_gnt), 64'd0);
        chk("rst_master_rdata", 64'(|bif.master_rdata), 64'd0);
        chk("rst_device_re", 64'(bif.device_re), 64'd0);
        chk("rst_device_we", 64'(bif.device_we), 64'd0);
        chk("rst_device_addr", 64'(|bif.device_addr), 64'd0);
        chk("rst_device_wdata", 64'(|bif.device_wdata), 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);

        for (int k = 0; k < 9; k++) run_vec(vt[k], k);

        // reset during a device wait state abandons the transfer
        bif.master_req_addr[0]   = 32'h3000_0000;
        bif.master_read_write[0] = 1'b1;
        bif.master_wdata[0]      = 32'h0000_0001;
        bif.master_req           = 2'b01;
        strobe_cnt = 0;
        for (int i = 0; i < 3; i++) step_resp(0, '0);
        chk("mid_strobes", 64'(strobe_cnt), 64'd3);
        chk("mid_err_before", 64'(bus_err), 64'd1);
        rst_i = 1'b1;
        step_resp(0, '0);
        chk("mid_rst_re", 64'(bif.device_re), 64'd0);
        chk("mid_rst_we", 64'(bif.device_we), 64'd0);
        chk("mid_rst_gnt", 64'(bif.master_gnt), 64'd0);
        chk("mid_rst_err", 64'(bus_err), 64'd0);
        rst_i          = 1'b0;
        bif.master_req = '0;
        gacc = '0;
        for (int i = 0; i < 4; i++) begin
            step_resp(0, '0);
            gacc = gacc | bif.master_gnt;
        end
        chk("mid_no_late_gnt", 64'(gacc), 64'd0);

        // contention: both masters request continuously
        bif.master_req_addr[0]   = 32'h3000_0100;
        bif.master_req_addr[1]   = 32'h4000_0200;
        bif.master_read_write    = 2'b00;
        bif.master_req           = 2'b11;
        strobe_cnt = 0;
        g   = 0;
        cyc = 0;
        while (g < 4 && cyc < 100) begin
            step_resp(1, 32'h1000_0000 + 32'(g));
            cyc++;
            if (bif.master_gnt != '0) begin
                chk($sformatf("rr_gnt%0d", g), 64'(bif.master_gnt),
                    64'(1 << (g % 2)));
                chk($sformatf("rr_rdata%0d", g),
                    64'(bif.master_rdata[g % 2]),
                    64'(32'h1000_0000 + 32'(g)));
                strobe_cnt = 0;
                g++;
            end
        end
        chk("rr_grant_count", 64'(g), 64'd4);
        bif.master_req = '0;
        step_resp(0, '0);
        step_resp(0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
